// File: rtl/solver_pkg.sv
// Shared types for the solver arbiter: FSM states, operand widths and the
// response bundle handed back to requesters.
package solver_pkg;

  localparam int X_W      = 8;
  localparam int COEF_W   = 16;
  localparam int MAX_ID_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // id is sized for the largest supported requester count (8)
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [COEF_W-1:0]   result;
    logic                zero;
    logic                overflow;
    logic                timeout;
  } rsp_t;

endpackage

// File: rtl/solver_arbiter_picker.sv
// rr_picker: combinational round-robin selector, first set request at or
// after ptr (wrapping), returned both one-hot and as an index.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  // Rotate the request vector so ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    doubled = {req, req};
    rotated = N_REQ'(doubled >> ptr);
    valid   = |req;
    off     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) off = ID_W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (ID_W + 1)'(N_REQ)) sum = sum - (ID_W + 1)'(N_REQ);
    idx   = sum[ID_W-1:0];
    grant = '0;
    if (valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/solver_arbiter.sv
// solver_arbiter: round-robin sharing of one expression_solver among N_REQ
// requesters. Optional BUSY watchdog enabled by macro SOLVER_TIMEOUT_EN.
module solver_arbiter
  import solver_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int ID_W           = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*X_W-1:0]    req_x,
  input  logic [N_REQ*COEF_W-1:0] req_a,
  input  logic [N_REQ*COEF_W-1:0] req_b,
  input  logic [N_REQ*COEF_W-1:0] req_c,
  output logic [N_REQ-1:0]        grant,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [COEF_W-1:0]       rsp_result,
  output logic                    rsp_zero,
  output logic                    rsp_overflow,
  output logic                    rsp_timeout,
  output logic                    slv_rst,
  output logic                    slv_start,
  output logic [X_W-1:0]          slv_x,
  output logic [COEF_W-1:0]       slv_a,
  output logic [COEF_W-1:0]       slv_b,
  output logic [COEF_W-1:0]       slv_c,
  input  logic [COEF_W-1:0]       slv_result,
  input  logic                    slv_zero,
  input  logic                    slv_overflow,
  input  logic                    slv_completed
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("solver_arbiter: unsupported parameter values");
  end

  state_e          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_id;
  rsp_t            rsp_q;
  logic            pick_valid;
  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0] pick_idx;
  logic            tmo_hit;

  rr_picker #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .req  (req),
    .ptr  (rr_ptr),
    .valid(pick_valid),
    .grant(pick_grant),
    .idx  (pick_idx)
  );

`ifdef SOLVER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts BUSY cycles; saturates at the limit so a late completion still wins.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || state != ST_BUSY) tmo_cnt <= '0;
    else if (!tmo_hit)           tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      gnt_id <= '0;
      grant  <= '0;
      slv_x  <= '0;
      slv_a  <= '0;
      slv_b  <= '0;
      slv_c  <= '0;
      rsp_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant  <= pick_grant;
            gnt_id <= pick_idx;
            slv_x  <= req_x[pick_idx*X_W +: X_W];
            slv_a  <= req_a[pick_idx*COEF_W +: COEF_W];
            slv_b  <= req_b[pick_idx*COEF_W +: COEF_W];
            slv_c  <= req_c[pick_idx*COEF_W +: COEF_W];
            rr_ptr <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A real completion takes priority over a watchdog expiring on the same edge
          if (slv_completed) begin
            rsp_q.id       <= MAX_ID_W'(gnt_id);
            rsp_q.result   <= slv_result;
            rsp_q.zero     <= slv_zero;
            rsp_q.overflow <= slv_overflow;
            rsp_q.timeout  <= 1'b0;
            grant          <= '0;
            state          <= ST_RESP;
          end else if (tmo_hit) begin
            rsp_q.id       <= MAX_ID_W'(gnt_id);
            rsp_q.result   <= '0;
            rsp_q.zero     <= 1'b0;
            rsp_q.overflow <= 1'b0;
            rsp_q.timeout  <= 1'b1;
            grant          <= '0;
            state          <= ST_RESP;
          end
        end
        ST_RESP:    state <= ST_RELEASE;
        ST_RELEASE: if (!slv_completed) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign slv_start    = (state == ST_BUSY);
  assign rsp_valid    = (state == ST_RESP);
  assign rsp_id       = ID_W'(rsp_q.id);
  assign rsp_result   = rsp_q.result;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_timeout  = rsp_q.timeout;
  assign slv_rst      = rst | (rsp_valid & rsp_q.timeout);

endmodule

// File: tb/tb_solver_arbiter.sv
// Bench for solver_arbiter: a stub solver with programmable latency answers from
// lookup tables; grants are predicted by a simple pending-set round-robin model.
`timescale 1ns/1ps
module tb_solver_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*8-1:0]   req_x;
  logic [N*16-1:0]  req_a, req_b, req_c;
  logic [N-1:0]     grant;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [15:0]      rsp_result;
  logic             rsp_zero, rsp_overflow, rsp_timeout;
  logic             slv_rst, slv_start;
  logic [7:0]       slv_x;
  logic [15:0]      slv_a, slv_b, slv_c;
  logic [15:0]      slv_result;
  logic             slv_zero, slv_overflow, slv_completed;

  int checks = 0;
  int errors = 0;

  logic [15:0] res_tbl  [16];
  logic        zero_tbl [16];
  logic        ovf_tbl  [16];
  int          stub_lat  = 1;
  bit          stub_hang = 1'b0;
  int          stub_cnt  = 0;

  logic [N-1:0] pend;
  logic [7:0]   mx [N];
  logic [15:0]  ma [N], mb [N], mc [N];
  int           mptr;

  int           n, bad, nrst, nrsp;
  logic [N-1:0] oh;

  solver_arbiter #(
    .N_REQ         (N),
    .ID_W          (IDW),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_x        (req_x),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_c        (req_c),
    .grant        (grant),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_timeout  (rsp_timeout),
    .slv_rst      (slv_rst),
    .slv_start    (slv_start),
    .slv_x        (slv_x),
    .slv_a        (slv_a),
    .slv_b        (slv_b),
    .slv_c        (slv_c),
    .slv_result   (slv_result),
    .slv_zero     (slv_zero),
    .slv_overflow (slv_overflow),
    .slv_completed(slv_completed)
  );

  always #5 clk = ~clk;

  // Stub solver: completes once start has been seen on stub_lat rising edges.
  always @(posedge clk) begin
    if (slv_rst || !slv_start) stub_cnt <= 0;
    else if (stub_cnt < 100000) stub_cnt <= stub_cnt + 1;
  end
  assign slv_completed = !stub_hang && (stub_cnt >= stub_lat);
  assign slv_result    = res_tbl[slv_x[3:0]];
  assign slv_zero      = zero_tbl[slv_x[3:0]];
  assign slv_overflow  = ovf_tbl[slv_x[3:0]];

  function automatic int model_pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic applyStimulus();
    req = pend;
    for (int i = 0; i < N; i++) begin
      req_x[i*8 +: 8]   = mx[i];
      req_a[i*16 +: 16] = ma[i];
      req_b[i*16 +: 16] = mb[i];
      req_c[i*16 +: 16] = mc[i];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_grant"}, 32'(grant), 0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    checkOutput({tag, "_slv_start"}, 32'(slv_start), 0);
    checkOutput({tag, "_slv_rst"}, 32'(slv_rst), 1);
    checkOutput({tag, "_slv_x"}, 32'(slv_x), 0);
    checkOutput({tag, "_slv_a"}, 32'(slv_a), 0);
    checkOutput({tag, "_slv_b"}, 32'(slv_b), 0);
    checkOutput({tag, "_slv_c"}, 32'(slv_c), 0);
    checkOutput({tag, "_rsp_result"}, 32'(rsp_result), 0);
    checkOutput({tag, "_rsp_flags"}, {29'd0, rsp_zero, rsp_overflow, rsp_timeout}, 0);
  endtask

  // One job: add requesters, expect the model's winner, then its tagged response.
  task automatic run_job(input logic [N-1:0] add, input int lat, input int drop_after, input int fx);
    int           w, k, hold_bad;
    logic [N-1:0] exp_oh;
    logic [7:0]   ex;
    logic [15:0]  ea, eb, ec;
    for (int i = 0; i < N; i++) begin
      if (add[i] && !pend[i]) begin
        mx[i] = (fx >= 0) ? 8'(fx) : 8'($urandom);
        ma[i] = 16'($urandom);
        mb[i] = 16'($urandom);
        mc[i] = 16'($urandom);
      end
    end
    pend     = pend | add;
    stub_lat = lat;
    applyStimulus();
    w      = model_pick(pend, mptr);
    exp_oh = '0;
    if (w >= 0) exp_oh[w] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (grant === '0 && k < 12);
    checkOutput("job_grant", 32'(grant), 32'(exp_oh));
    if (w < 0) return;
    ex = mx[w]; ea = ma[w]; eb = mb[w]; ec = mc[w];
    checkOutput("job_slv_x", 32'(slv_x), 32'(ex));
    checkOutput("job_slv_a", 32'(slv_a), 32'(ea));
    checkOutput("job_slv_b", 32'(slv_b), 32'(eb));
    checkOutput("job_slv_c", 32'(slv_c), 32'(ec));
    mptr  = (w + 1) % N;
    mx[w] = ~mx[w];
    ma[w] = ~ma[w];
    applyStimulus();
    k        = 0;
    hold_bad = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == drop_after) begin
        pend[w] = 1'b0;
        applyStimulus();
      end
      if (!rsp_valid && (grant !== exp_oh || slv_x !== ex || slv_a !== ea)) hold_bad++;
    end while (!rsp_valid && k < lat + 20);
    checkOutput("job_latency", k, lat + 1);
    checkOutput("job_rsp_id", 32'(rsp_id), w);
    checkOutput("job_rsp_result", 32'(rsp_result), 32'(res_tbl[ex[3:0]]));
    checkOutput("job_rsp_zero", 32'(rsp_zero), 32'(zero_tbl[ex[3:0]]));
    checkOutput("job_rsp_overflow", 32'(rsp_overflow), 32'(ovf_tbl[ex[3:0]]));
    checkOutput("job_rsp_timeout", 32'(rsp_timeout), 0);
    checkOutput("job_busy_hold", hold_bad, 0);
    pend[w] = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("job_rsp_pulse", 32'(rsp_valid), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      res_tbl[i]  = 16'($urandom);
      zero_tbl[i] = 1'($urandom_range(0, 1));
      ovf_tbl[i]  = 1'($urandom_range(0, 1));
    end
    res_tbl[15] = 16'h1234; zero_tbl[15] = 1'b0; ovf_tbl[15] = 1'b0;
    res_tbl[5]  = 16'h0000; zero_tbl[5]  = 1'b1; ovf_tbl[5]  = 1'b0;
    for (int i = 0; i < N; i++) begin
      mx[i] = '0; ma[i] = '0; mb[i] = '0; mc[i] = '0;
    end
    pend = '0;
    mptr = 0;
    applyStimulus();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkReset("por");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single request");
    stub_lat = 5;
    mx[0] = 8'd15; ma[0] = 16'd96; mb[0] = 16'd3; mc[0] = 16'd1;
    pend = 4'b0001;
    applyStimulus();
    @(negedge clk);
    checkOutput("single_grant", 32'(grant), 32'h1);
    checkOutput("single_start", 32'(slv_start), 1);
    checkOutput("single_slv_x", 32'(slv_x), 15);
    checkOutput("single_slv_a", 32'(slv_a), 96);
    checkOutput("single_slv_b", 32'(slv_b), 3);
    checkOutput("single_slv_c", 32'(slv_c), 1);
    mptr  = 1;
    mx[0] = 8'h3c; mb[0] = 16'hbeef;
    applyStimulus();
    n   = 1;
    bad = 0;
    while (!rsp_valid && n < 30) begin
      @(negedge clk);
      n++;
      if (slv_x !== 8'd15 || slv_b !== 16'd3) bad++;
    end
    checkOutput("single_latency", n, 7);
    checkOutput("single_rsp_id", 32'(rsp_id), 0);
    checkOutput("single_rsp_result", 32'(rsp_result), 32'h1234);
    checkOutput("single_operand_hold", bad, 0);
    pend = '0;
    applyStimulus();
    @(negedge clk);
    checkOutput("single_rsp_pulse", 32'(rsp_valid), 0);
    @(negedge clk);

    $display("[TB] reset mid-job");
    mx[1] = 8'($urandom); ma[1] = 16'($urandom);
    stub_lat = 12;
    pend = 4'b0010;
    applyStimulus();
    @(negedge clk);
    checkOutput("rstjob_grant", 32'(grant), 32'h2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkReset("midjob");
    pend = '0;
    applyStimulus();
    rst  = 1'b0;
    mptr = 0;
    nrsp = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    checkOutput("midjob_no_rsp", nrsp, 0);
    run_job(4'b1001, 3, 0, -1);
    run_job(4'b0000, 2, 0, -1);

    $display("[TB] fairness");
    for (int j = 0; j < 5; j++) run_job(4'b1111, $urandom_range(1, 6), 0, -1);
    pend = '0;
    applyStimulus();
    repeat (2) @(negedge clk);

    $display("[TB] drop after grant");
    mptr = 2;
    run_job(4'b0100, 6, 3, 5);
    run_job(4'b0001, 4, 0, -1);
    mptr = 1;

    $display("[TB] random jobs");
    for (int j = 0; j < 20; j++) begin
      run_job(4'($urandom_range(1, 15)), $urandom_range(1, 6),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, -1);
    end
    pend = '0;
    applyStimulus();
    repeat (2) @(negedge clk);

    $display("[TB] hung solver");
    stub_hang = 1'b1;
    mx[0] = 8'd15; ma[0] = 16'($urandom); mb[0] = 16'($urandom); mc[0] = 16'($urandom);
    pend = 4'b0001;
    applyStimulus();
    oh   = 4'b0001;
    n    = 0;
    bad  = 0;
    nrst = 0;
    nrsp = 0;
`ifdef SOLVER_TIMEOUT_EN
    do begin
      @(negedge clk);
      n++;
      if (slv_rst) nrst++;
      if (!rsp_valid && grant !== oh) bad++;
    end while (!rsp_valid && n < 100);
    checkOutput("tmo_latency", n, 66);
    checkOutput("tmo_flag", 32'(rsp_timeout), 1);
    checkOutput("tmo_result", 32'(rsp_result), 0);
    checkOutput("tmo_zero_ovf", {30'd0, rsp_zero, rsp_overflow}, 0);
    checkOutput("tmo_rsp_id", 32'(rsp_id), 0);
    checkOutput("tmo_grant_hold", bad, 0);
    pend = '0;
    applyStimulus();
    repeat (4) begin
      @(negedge clk);
      if (slv_rst) nrst++;
    end
    checkOutput("tmo_slv_rst_cycles", nrst, 1);
`else
    repeat (200) begin
      @(negedge clk);
      n++;
      if (rsp_valid) nrsp++;
      if (slv_rst) nrst++;
      if (grant !== oh) bad++;
    end
    checkOutput("hang_no_rsp", nrsp, 0);
    checkOutput("hang_grant_hold", bad, 0);
    checkOutput("hang_start_held", 32'(slv_start), 1);
    checkOutput("hang_no_slv_rst", nrst, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
